fifo_stream_reader: RTL and testbench

- Read-side drain engine for the dual-clock FIFO; lives entirely in the FIFO read clock domain.
- Issues FIFO read strobes under credit control and absorbs the RAM read latency in a small prefetch buffer.
- Presents the data as a valid/ready stream to downstream logic (e.g. the LED output path).
- Counts accepted beats and marks frame boundaries with m_last.

---
 rtl/fifo_stream_reader.sv | 198 +++++++++++++++++++
 tb/tb_fifo_stream_reader.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side drain engine for the dual-clock FIFO. Lives entirely in the FIFO
// read clock domain. It issues FIFO read strobes under credit control, absorbs
// the RAM read latency in a small prefetch buffer, and presents the words as a
// valid/ready stream. Accepted beats are counted and frame boundaries are
// marked with m_last.
//
// Ports:
//   clk              read-domain clock (FIFO oclk)
//   reset            synchronous, active-high; asserted together with FIFO oreset
//   fifo_rd          FIFO read enable (ord), combinational from registers and
//                    fifo_full_count
//   fifo_data        FIFO odata
//   fifo_data_valid  FIFO odata_valid
//   fifo_full_count  FIFO ofull_count (ADDR_WIDTH+1 bits), lags fifo_rd by 1 cycle
//   fifo_underflow   FIFO ounderflow
//   frame_len        beats per frame, 0 = no framing; sampled at frame boundaries
//   m_data           stream data (prefetch buffer head)
//   m_valid          stream valid
//   m_ready          stream ready
//   m_last           last beat of the frame, qualified by m_valid
//   err              sticky protocol error, cleared only by reset
//
// Stream handshake: a beat transfers on every rising clk edge where
// m_valid && m_ready. Once m_valid is high it stays high, and m_data/m_last
// stay stable, until the beat transfers. m_valid never depends on m_ready.
//
// Parameter constraints: BUF_DEPTH must be a power of 2 and at least
// READ_LATENCY+2, so the pointers can wrap naturally and the credit window
// covers a full read round trip at one beat per cycle.
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 16,
  parameter int BUF_DEPTH    = 4,
  parameter int READ_LATENCY = 1,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_data_valid,
  input  logic [ADDR_WIDTH:0]   fifo_full_count,
  input  logic                  fifo_underflow,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  err
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int FL_W  = $clog2(READ_LATENCY + 2);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] buf_mem_q [BUF_DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q,   rd_ptr_d;
  logic [OCC_W-1:0]     occ_q,      occ_d;
  logic [OCC_W-1:0]     inflight_q, inflight_d;
  logic [LEN_WIDTH-1:0] cnt_q,      cnt_d;
  logic [LEN_WIDTH-1:0] len_q,      len_d;
  logic [FL_W-1:0]      flush_q,    flush_d;
  logic                 rd_q,       rd_d;
  logic                 err_q,      err_d;

  // ---------------------------------------------------------------------------
  // Internal strobes
  // ---------------------------------------------------------------------------
  logic             avail_pos;   // FIFO holds words not yet claimed by a read
  logic [OCC_W:0]   credit_used; // buffered words plus reads still in flight
  logic             credit_ok;
  logic             take_dv;     // returning word that matches an issued read
  logic             stray_dv;    // returning word with no read outstanding
  logic             buf_full;
  logic             push;
  logic             pop;

  // ---------------------------------------------------------------------------
  // Read issue
  // ---------------------------------------------------------------------------
  // fifo_full_count only reflects a read one cycle after it is issued, so the
  // read issued last cycle (rd_q) is subtracted to get the true availability.
  // avail = fifo_full_count - rd_q > 0 is evaluated as a compare so a count
  // of 0 with rd_q=1 cannot wrap into a huge positive value.
  always_comb begin
    avail_pos   = fifo_full_count > {{ADDR_WIDTH{1'b0}}, rd_q};
    credit_used = {1'b0, occ_q} + {1'b0, inflight_q};
    credit_ok   = credit_used < (OCC_W + 1)'(BUF_DEPTH);
    fifo_rd     = !reset && avail_pos && credit_ok;
  end

  // ---------------------------------------------------------------------------
  // Stream outputs (no bypass: data is always served from the buffer)
  // ---------------------------------------------------------------------------
  always_comb begin
    m_valid = (occ_q != '0);
    m_data  = buf_mem_q[rd_ptr_q];
    m_last  = m_valid && (len_q != '0) && (cnt_q == (len_q - LEN_WIDTH'(1)));
    err     = err_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    take_dv  = fifo_data_valid && (inflight_q != '0);
    stray_dv = fifo_data_valid && (inflight_q == '0);
    buf_full = (occ_q == OCC_W'(BUF_DEPTH));
    // A word arriving into a full buffer is dropped; the credit rule makes
    // this impossible, so it only shows up as an error.
    push     = take_dv && !buf_full;
    pop      = m_valid && m_ready;

    rd_d     = fifo_rd;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    // A returning word retires its read even if it had to be dropped, so the
    // credit window never leaks.
    unique case ({fifo_rd, take_dv})
      2'b10:   inflight_d = inflight_q + OCC_W'(1);
      2'b01:   inflight_d = inflight_q - OCC_W'(1);
      default: inflight_d = inflight_q;
    endcase

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    // The flush window covers RAM output still in the pipe when reset hit;
    // stray words inside it are stale and dropped without complaint.
    flush_d = (flush_q != '0) ? flush_q - FL_W'(1) : flush_q;

    err_d = err_q
          | fifo_underflow
          | (stray_dv && (flush_q == '0))
          | (take_dv && buf_full);

    // Frame length is only re-sampled on the last beat, so mid-frame changes
    // take effect from the next frame. With len_q==0 the counter free-runs.
    cnt_d = cnt_q;
    len_d = len_q;
    if (pop) begin
      if (m_last) begin
        cnt_d = '0;
        len_d = frame_len;
      end else begin
        cnt_d = cnt_q + LEN_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      len_q      <= frame_len;
      flush_q    <= FL_W'(READ_LATENCY + 1);
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      flush_q    <= flush_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
    end
  end

  // Buffer storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem_q[wr_ptr_q] <= fifo_data;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Bench for fifo_stream_reader. A small FIFO/RAM model supplies data with a
// one-cycle read latency and a one-cycle lag on the full count. Table-driven
// vectors cover per-cycle read latency and framing; hand-written sequences
// cover backpressure, count lag, error detection and reset mid-stream.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

  localparam int AW = 13;
  localparam int DW = 16;
  localparam int BD = 4;
  localparam int RL = 1;
  localparam int LW = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          fifo_rd;
  logic [DW-1:0] fifo_data;
  logic          fifo_data_valid;
  logic [AW:0]   fifo_full_count;
  logic          fifo_underflow;
  logic [LW-1:0] frame_len;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          err;

  logic          model_dv;
  logic [DW-1:0] model_data;
  logic          inj_dv;
  logic [DW-1:0] inj_data;

  assign fifo_data_valid = model_dv | inj_dv;
  assign fifo_data       = inj_dv ? inj_data : model_data;

  fifo_stream_reader #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .BUF_DEPTH   (BD),
    .READ_LATENCY(RL),
    .LEN_WIDTH   (LW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_rd        (fifo_rd),
    .fifo_data      (fifo_data),
    .fifo_data_valid(fifo_data_valid),
    .fifo_full_count(fifo_full_count),
    .fifo_underflow (fifo_underflow),
    .frame_len      (frame_len),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .err            (err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int beat_cnt = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          last_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // FIFO / RAM model: read latency 1, full count reported one cycle late
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    if (reset) begin
      fifo_q.delete();
      fifo_full_count <= '0;
      model_dv        <= 1'b0;
      model_data      <= '0;
    end else begin
      fifo_full_count <= (AW + 1)'(fifo_q.size());
      model_dv        <= 1'b0;
      if (fifo_rd) begin
        n_checks++;
        if (fifo_q.size() == 0) begin
          n_fail++;
          $display("FAIL fifo_model_underflow: got read with level 0, expected no read (t=%0t)", $time);
        end else begin
          model_data <= fifo_q.pop_front();
          model_dv   <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stream monitor: checks every accepted beat against the expected queue
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    logic [DW-1:0] e;
    if (!reset) begin
      if (fifo_rd) rd_cnt++;
      if (m_valid && m_ready) begin
        beat_cnt++;
        last_log.push_back(m_last);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got beat 0x%0h, expected no beat (t=%0t)", m_data, $time);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            n_fail++;
            $display("FAIL beat_data: got 0x%0h, expected 0x%0h (t=%0t)", m_data, e, $time);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns #1 after the last edge that sampled reset high (start of cycle 0).
  task automatic do_reset(input logic [LW-1:0] flen);
    frame_len = flen;
    reset     = 1'b1;
    step(3);
    exp_q.delete();
    last_log.delete();
    reset = 1'b0;
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + DW'(i));
      exp_q.push_back(base + DW'(i));
    end
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (beat_cnt < target && c < budget) begin
      step(1);
      c++;
    end
    check(name, beat_cnt, target);
  endtask

  // ---------------------------------------------------------------------------
  // Vector tables
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          ready;
    logic          exp_rd;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
  } lat_vec_t;

  typedef struct {
    logic [LW-1:0] len0;
    logic [LW-1:0] len1;
    int            change_at;
    int            n_beats;
    logic [15:0]   exp_mask;
  } frame_vec_t;

  lat_vec_t   lat_tbl[8];
  frame_vec_t frm_tbl[4];

  int          rd0;
  int          b0;
  logic        changed;
  logic [15:0] mask;

  initial begin
    reset          = 1'b1;
    m_ready        = 1'b0;
    frame_len      = '0;
    fifo_underflow = 1'b0;
    inj_dv         = 1'b0;
    inj_data       = '0;

    // Cycle-by-cycle view after 3 words land in the FIFO in cycle 0.
    lat_tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0000};
    lat_tbl[1] = '{1'b1, 1'b1, 1'b0, 16'h0000};
    lat_tbl[2] = '{1'b1, 1'b1, 1'b0, 16'h0000};
    lat_tbl[3] = '{1'b1, 1'b1, 1'b1, 16'hA000};
    lat_tbl[4] = '{1'b1, 1'b0, 1'b1, 16'hA001};
    lat_tbl[5] = '{1'b1, 1'b0, 1'b1, 16'hA002};
    lat_tbl[6] = '{1'b1, 1'b0, 1'b0, 16'h0000};
    lat_tbl[7] = '{1'b1, 1'b0, 1'b0, 16'h0000};

    // bit i of exp_mask = m_last on beat i
    frm_tbl[0] = '{16'd3, 16'd3, -1, 12, 16'h0924};
    frm_tbl[1] = '{16'd3, 16'd2,  3, 14, 16'h2AA4};
    frm_tbl[2] = '{16'd0, 16'd0, -1, 10, 16'h0000};
    frm_tbl[3] = '{16'd1, 16'd1, -1,  8, 16'h00FF};

    // ---- reset state ----
    step(2);
    @(negedge clk);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last",  m_last,  0);
    check("rst_err",     err,     0);

    // ---- basic latency (table) ----
    do_reset(16'd0);
    push_words(3, 16'hA000);
    for (int i = 0; i < 8; i++) begin
      m_ready = lat_tbl[i].ready;
      @(negedge clk);
      check($sformatf("lat_rd_c%0d", i),    fifo_rd, lat_tbl[i].exp_rd);
      check($sformatf("lat_valid_c%0d", i), m_valid, lat_tbl[i].exp_valid);
      if (lat_tbl[i].exp_valid)
        check($sformatf("lat_data_c%0d", i), m_data, lat_tbl[i].exp_data);
      @(posedge clk);
      #1;
    end
    check("lat_all_consumed", exp_q.size(), 0);

    // ---- backpressure ----
    m_ready = 1'b0;
    do_reset(16'd0);
    rd0 = rd_cnt;
    b0  = beat_cnt;
    push_words(100, 16'hB000);
    step(10);
    check("bp_reads_issued", rd_cnt - rd0, 4);
    check("bp_rd_stalled",   fifo_rd, 0);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid_hold", m_valid, 1);
      check("bp_data_hold",  m_data,  16'hB000);
      step(1);
    end
    m_ready = 1'b1;
    step(1);
    check("bp_reads_resume", fifo_rd, 1);
    for (int i = 0; i < 20; i++) begin
      check("bp_no_gap", m_valid, 1);
      step(1);
    end
    check("bp_beats", beat_cnt - b0, 21);
    m_ready = 1'b0;

    // ---- framing (table) ----
    for (int k = 0; k < 4; k++) begin
      m_ready = 1'b0;
      do_reset(frm_tbl[k].len0);
      b0 = beat_cnt;
      m_ready = 1'b1;
      push_words(frm_tbl[k].n_beats, DW'(16'h1000 + k * 16'h0100));
      changed = 1'b0;
      for (int c = 0; c < 200 && (beat_cnt - b0) < frm_tbl[k].n_beats; c++) begin
        step(1);
        if (frm_tbl[k].change_at >= 0 && !changed && last_log.size() >= frm_tbl[k].change_at) begin
          frame_len = frm_tbl[k].len1;
          changed   = 1'b1;
        end
      end
      check($sformatf("frm%0d_beats", k), beat_cnt - b0, frm_tbl[k].n_beats);
      mask = '0;
      for (int i = 0; i < last_log.size() && i < 16; i++) mask[i] = last_log[i];
      check($sformatf("frm%0d_last_mask", k), mask, frm_tbl[k].exp_mask);
    end
    m_ready = 1'b0;

    // ---- count lag edge ----
    do_reset(16'd0);
    rd0 = rd_cnt;
    b0  = beat_cnt;
    m_ready = 1'b1;
    push_words(1, 16'hE000);
    step(8);
    check("lag_single_read", rd_cnt - rd0, 1);
    check("lag_single_beat", beat_cnt - b0, 1);
    check("lag_err",         err, 0);
    m_ready = 1'b0;

    // ---- underflow error ----
    do_reset(16'd0);
    step(2);
    fifo_underflow = 1'b1;
    step(1);
    fifo_underflow = 1'b0;
    check("uf_err_set", err, 1);
    step(5);
    check("uf_err_sticky", err, 1);
    do_reset(16'd0);
    check("uf_err_cleared", err, 0);

    // ---- stray data valid: inside flush window vs after it ----
    step(1);
    inj_dv   = 1'b1;
    inj_data = 16'h5A5A;
    step(1);
    inj_dv = 1'b0;
    check("flush_drop_err",   err, 0);
    check("flush_drop_valid", m_valid, 0);
    step(3);
    inj_dv = 1'b1;
    step(1);
    inj_dv = 1'b0;
    check("stray_err_set",   err, 1);
    check("stray_drop_valid", m_valid, 0);

    // ---- reset mid-stream ----
    do_reset(16'd0);
    push_words(100, 16'hC000);
    step(4);
    check("mid_valid_before", m_valid, 1);
    reset = 1'b1;
    step(1);
    check("mid_valid_reset",  m_valid, 0);
    check("mid_rd_reset",     fifo_rd, 0);
    step(1);
    exp_q.delete();
    last_log.delete();
    reset = 1'b0;
    step(1);
    inj_dv   = 1'b1;
    inj_data = 16'hDEAD;
    step(1);
    inj_dv = 1'b0;
    check("mid_stale_err",   err, 0);
    check("mid_stale_valid", m_valid, 0);
    step(3);
    check("mid_idle_valid", m_valid, 0);
    b0 = beat_cnt;
    m_ready = 1'b1;
    push_words(5, 16'hD000);
    wait_beats(b0 + 5, 50, "mid_restart_beats");
    check("mid_restart_err",   err, 0);
    check("mid_restart_drain", exp_q.size(), 0);
    m_ready = 1'b0;

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout at t=%0t, expected test completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
